// File: rtl/dkongjr_snd_pkg.sv
// Shared encodings and sizes for the sound-CPU program loader.
// Holds the FSM state type, fixed window lengths and the hold-timer preset helper.
package dkongjr_snd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam int ARM_CYCLES = 2;
    localparam int SND_ROM_AW = 12;
    localparam int CNT_W      = SND_ROM_AW + 1;
    localparam int TMR_W      = 8;

    // The timer flags zero on the final cycle of a window, so it is preset to length-1.
    function automatic logic [TMR_W-1:0] tmr_preset(input int cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/dkongjr_hold_timer.sv
// Loadable down-counter; zero_o is high on the last cycle of a window loaded with length-1.
// Latency: load takes effect next cycle; no backpressure, load always wins over counting.
module dkongjr_hold_timer
    import dkongjr_snd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dkongjr_snd_prog_loader.sv
// Streams the sound-CPU image into program RAM while holding the 8035 in reset.
// Accept-to-WE latency 1 cycle; READY only in WAIT, so one byte per WR_CYCLES+1 cycles.
module dkongjr_snd_prog_loader
    import dkongjr_snd_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h4000,
    parameter int          ROM_SIZE  = 4096,
    parameter int          WR_CYCLES = 2,
    parameter int          RST_HOLD  = 16
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_DL_START,
    input  logic                  I_DL_VALID,
    output logic                  O_DL_READY,
    input  logic [15:0]           I_DL_ADDR,
    input  logic [7:0]            I_DL_DATA,
    input  logic                  I_DL_DONE,
    output logic [SND_ROM_AW-1:0] O_CNF_A,
    output logic [7:0]            O_CNF_D,
    output logic                  O_WE0,
    output logic                  O_CNF_EN,
    output logic                  O_SND_RSTn,
    output logic                  O_BUSY,
    output logic                  O_ERR,
    output logic [CNT_W-1:0]      O_COUNT,
    output logic [7:0]            O_CHKSUM
);

    localparam logic [TMR_W-1:0] ARM_PRESET  = tmr_preset(ARM_CYCLES);
    localparam logic [TMR_W-1:0] WR_PRESET   = tmr_preset(WR_CYCLES);
    localparam logic [TMR_W-1:0] HOLD_PRESET = tmr_preset(RST_HOLD);
    localparam logic [16:0]      ROM_SIZE_W  = 17'(ROM_SIZE);
    localparam logic [CNT_W-1:0] ROM_SIZE_C  = CNT_W'(ROM_SIZE);

    state_t                  state_q, state_d;
    logic [SND_ROM_AW-1:0]   cnf_a_q, cnf_a_d;
    logic [7:0]              cnf_dat_q, cnf_dat_d;
    logic                    we_q, we_d;
    logic                    cnf_en_q, cnf_en_d;
    logic                    snd_rstn_q, snd_rstn_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [7:0]              chksum_q, chksum_d;
    logic                    ready_q, ready_d;
    logic                    done_pend_q, done_pend_d;

    logic                    tmr_load;
    logic [TMR_W-1:0]        tmr_val;
    logic                    tmr_zero;

    logic [15:0]             dl_off;
    logic                    in_win;
    logic                    done_any;

    // Addresses below BASE_ADDR wrap to a large offset and fall outside the window.
    assign dl_off   = I_DL_ADDR - BASE_ADDR;
    assign in_win   = ({1'b0, dl_off} < ROM_SIZE_W);
    assign done_any = done_pend_q | I_DL_DONE;

    dkongjr_hold_timer u_hold_timer (
        .clk_i      (I_CLK),
        .rst_i      (I_RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        cnf_a_d     = cnf_a_q;
        cnf_dat_d   = cnf_dat_q;
        we_d        = we_q;
        cnf_en_d    = cnf_en_q;
        snd_rstn_d  = snd_rstn_q;
        err_d       = err_q;
        count_d     = count_q;
        chksum_d    = chksum_q;
        done_pend_d = done_pend_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        if (I_DL_START) begin
            // A new session always restarts from ARM, cutting short any write in flight.
            state_d     = ST_ARM;
            we_d        = 1'b0;
            cnf_en_d    = 1'b1;
            snd_rstn_d  = 1'b0;
            err_d       = 1'b0;
            count_d     = '0;
            chksum_d    = '0;
            done_pend_d = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = ARM_PRESET;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ARM: begin
                    if (I_DL_DONE) begin
                        done_pend_d = 1'b1;
                    end
                    if (tmr_zero) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A byte arriving with DONE is written before the release starts.
                    if (I_DL_VALID && ready_q) begin
                        done_pend_d = done_any;
                        if (in_win) begin
                            cnf_a_d   = dl_off[SND_ROM_AW-1:0];
                            cnf_dat_d = I_DL_DATA;
                            we_d      = 1'b1;
                            state_d   = ST_WRITE;
                            tmr_load  = 1'b1;
                            tmr_val   = WR_PRESET;
                        end
                    end else if (done_any) begin
                        state_d     = ST_RELEASE;
                        err_d       = (count_q != ROM_SIZE_C);
                        cnf_en_d    = 1'b0;
                        done_pend_d = 1'b0;
                        tmr_load    = 1'b1;
                        tmr_val     = HOLD_PRESET;
                    end
                end
                ST_WRITE: begin
                    if (I_DL_DONE) begin
                        done_pend_d = 1'b1;
                    end
                    if (tmr_zero) begin
                        we_d     = 1'b0;
                        count_d  = count_q + 1'b1;
                        chksum_d = chksum_q + cnf_dat_q;
                        state_d  = ST_WAIT;
                    end
                end
                ST_RELEASE: begin
                    if (tmr_zero) begin
                        snd_rstn_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q     <= ST_IDLE;
            cnf_a_q     <= '0;
            cnf_dat_q   <= '0;
            we_q        <= 1'b0;
            cnf_en_q    <= 1'b0;
            snd_rstn_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
            chksum_q    <= '0;
            ready_q     <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnf_a_q     <= cnf_a_d;
            cnf_dat_q   <= cnf_dat_d;
            we_q        <= we_d;
            cnf_en_q    <= cnf_en_d;
            snd_rstn_q  <= snd_rstn_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            count_q     <= count_d;
            chksum_q    <= chksum_d;
            ready_q     <= ready_d;
            done_pend_q <= done_pend_d;
        end
    end

    assign O_DL_READY = ready_q;
    assign O_CNF_A    = cnf_a_q;
    assign O_CNF_D    = cnf_dat_q;
    assign O_WE0      = we_q;
    assign O_CNF_EN   = cnf_en_q;
    assign O_SND_RSTn = snd_rstn_q;
    assign O_BUSY     = busy_q;
    assign O_ERR      = err_q;
    assign O_COUNT    = count_q;
    assign O_CHKSUM   = chksum_q;

endmodule
